// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with fill count, programmable almost-full/almost-empty flags,
// selectable registered or first-word-fall-through read, and saturating error counters.
module sync_fifo_flex #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int PTR_WIDTH     = $clog2(DEPTH),
    parameter int AF_TH         = DEPTH - 2,
    parameter int AE_TH         = 2,
    parameter int FWFT          = 0,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wt_en,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     rvalid,
    output logic                     empty,
    output logic                     almost_empty,
    output logic                     underflow,
    output logic [PTR_WIDTH:0]       count,
    output logic [ERR_CNT_WIDTH-1:0] overflow_cnt,
    output logic [ERR_CNT_WIDTH-1:0] underflow_cnt,
    input  logic                     err_clr
);
    localparam logic [PTR_WIDTH:0] AF_LVL = (PTR_WIDTH + 1)'(AF_TH);
    localparam logic [PTR_WIDTH:0] AE_LVL = (PTR_WIDTH + 1)'(AE_TH);

    logic [DATA_WIDTH-1:0]    mem [DEPTH];

    logic [PTR_WIDTH:0]       wptr_reg, wptr_next;
    logic [PTR_WIDTH:0]       rptr_reg, rptr_next;
    logic [PTR_WIDTH:0]       count_reg, count_next;
    logic                     full_reg, full_next;
    logic                     empty_reg, empty_next;
    logic                     af_reg, af_next;
    logic                     ae_reg, ae_next;
    logic                     ovf_reg, ovf_next;
    logic                     unf_reg, unf_next;
    logic [ERR_CNT_WIDTH-1:0] ovf_cnt_reg, ovf_cnt_next;
    logic [ERR_CNT_WIDTH-1:0] unf_cnt_reg, unf_cnt_next;
    logic                     wr_acc;
    logic                     rd_acc;

    always_comb begin
        wr_acc     = wt_en && !full_reg;
        rd_acc     = rd_en && !empty_reg;
        wptr_next  = wptr_reg + (PTR_WIDTH + 1)'(wr_acc);
        rptr_next  = rptr_reg + (PTR_WIDTH + 1)'(rd_acc);
        count_next = count_reg + (PTR_WIDTH + 1)'(wr_acc) - (PTR_WIDTH + 1)'(rd_acc);
        // Flags come from the post-edge pointers; the MSB toggle separates full from empty.
        empty_next = (wptr_next == rptr_next);
        full_next  = (wptr_next[PTR_WIDTH-1:0] == rptr_next[PTR_WIDTH-1:0]) &&
                     (wptr_next[PTR_WIDTH] != rptr_next[PTR_WIDTH]);
        af_next    = (count_next >= AF_LVL);
        ae_next    = (count_next <= AE_LVL);
        ovf_next   = wt_en && full_reg;
        unf_next   = rd_en && empty_reg;
    end

    always_comb begin
        ovf_cnt_next = ovf_cnt_reg;
        unf_cnt_next = unf_cnt_reg;
        // Clear wins over a coincident event; the pulse itself is unaffected.
        if (err_clr) begin
            ovf_cnt_next = '0;
            unf_cnt_next = '0;
        end else begin
            if (ovf_next && (ovf_cnt_reg != '1))
                ovf_cnt_next = ovf_cnt_reg + ERR_CNT_WIDTH'(1);
            if (unf_next && (unf_cnt_reg != '1))
                unf_cnt_next = unf_cnt_reg + ERR_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg    <= '0;
            rptr_reg    <= '0;
            count_reg   <= '0;
            full_reg    <= 1'b0;
            empty_reg   <= 1'b1;
            af_reg      <= 1'b0;
            ae_reg      <= 1'b1;
            ovf_reg     <= 1'b0;
            unf_reg     <= 1'b0;
            ovf_cnt_reg <= '0;
            unf_cnt_reg <= '0;
        end else begin
            wptr_reg    <= wptr_next;
            rptr_reg    <= rptr_next;
            count_reg   <= count_next;
            full_reg    <= full_next;
            empty_reg   <= empty_next;
            af_reg      <= af_next;
            ae_reg      <= ae_next;
            ovf_reg     <= ovf_next;
            unf_reg     <= unf_next;
            ovf_cnt_reg <= ovf_cnt_next;
            unf_cnt_reg <= unf_cnt_next;
        end
    end

    // Storage is never cleared; a write coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc)
            mem[wptr_reg[PTR_WIDTH-1:0]] <= wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown as soon as it is stored; zero while empty.
            assign rdata  = empty_reg ? '0 : mem[rptr_reg[PTR_WIDTH-1:0]];
            assign rvalid = !empty_reg;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_reg;
            logic                  rvalid_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_reg  <= '0;
                    rvalid_reg <= 1'b0;
                end else begin
                    rvalid_reg <= rd_acc;
                    if (rd_acc)
                        rdata_reg <= mem[rptr_reg[PTR_WIDTH-1:0]];
                end
            end

            assign rdata  = rdata_reg;
            assign rvalid = rvalid_reg;
        end
    endgenerate

    assign full          = full_reg;
    assign almost_full   = af_reg;
    assign overflow      = ovf_reg;
    assign empty         = empty_reg;
    assign almost_empty  = ae_reg;
    assign underflow     = unf_reg;
    assign count         = count_reg;
    assign overflow_cnt  = ovf_cnt_reg;
    assign underflow_cnt = unf_cnt_reg;
endmodule
